uart_debug_ctrl: RTL and testbench

UART_DEBUG_CTRL -- requirements
Module: uart_debug_ctrl

---
 rtl/uart_debug_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_debug_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_ctrl.sv
// UART debug controller: decodes byte-framed host commands to write program/data
// memory, read data memory, run the CPU for a fixed window and dump acc/pc.
module uart_debug_ctrl #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int RUN_CYCLES = 256,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_done,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wdata,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    wr_pm,
  output logic                    wr_dm,
  output logic                    rd_dm,
  input  logic [8*DATA_BYTES-1:0] acc,
  input  logic [8*DATA_BYTES-1:0] pc,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic [7:0]              err_count
);

  localparam int DW     = 8 * DATA_BYTES;
  localparam int AB     = (ADDR_WIDTH + 7) / 8;
  localparam int MAXB   = (AB > DATA_BYTES) ? AB : DATA_BYTES;
  localparam int CNT_W  = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TXW    = 2 * DW;
  localparam int TXC_W  = $clog2(2 * DATA_BYTES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int RUN_W  = $clog2(RUN_CYCLES + 1);
  localparam int WAIT_W = $clog2(RD_LATENCY + 1);

  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_WR_PM = 8'h02;
  localparam logic [7:0] OP_WR_DM = 8'h03;
  localparam logic [7:0] OP_RD_DM = 8'h04;
  localparam logic [7:0] OP_DUMP  = 8'h05;
  localparam logic [7:0] OP_PING  = 8'h06;
  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_PONG = 8'hA5;
  localparam logic [7:0] BYTE_NAK = 8'hEE;

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, WRITE, READ_WAIT, RUN, TX_LOAD, TX_WAIT
  } state_e;

  state_e               state, next_state;
  logic [7:0]           opcode;
  logic [CNT_W-1:0]     byte_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [RUN_W-1:0]     run_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [TXW-1:0]       tx_buf;
  logic [TXC_W-1:0]     tx_left;
  logic                 err_inc;
  logic                 last_addr_byte, last_data_byte, tmo_hit, run_done, rd_ready;
  logic [ADDR_WIDTH-1:0] addr_upd;
  logic [DW-1:0]        wdata_upd;

  assign last_addr_byte = (byte_cnt == CNT_W'(AB - 1));
  assign last_data_byte = (byte_cnt == CNT_W'(DATA_BYTES - 1));
  assign tmo_hit        = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign run_done       = (run_cnt == RUN_W'(RUN_CYCLES));
  assign rd_ready       = (wait_cnt == WAIT_W'(RD_LATENCY));
  assign tx_data        = tx_buf[7:0];

  // Merge the incoming byte into its little-endian slot; address bits beyond
  // ADDR_WIDTH simply have no destination and are dropped.
  always_comb begin
    addr_upd  = mem_addr;
    wdata_upd = mem_wdata;
    for (int b = 0; b < ADDR_WIDTH; b++)
      if (b / 8 == int'(byte_cnt)) addr_upd[b] = rx_data[3'(b % 8)];
    for (int b = 0; b < DW; b++)
      if (b / 8 == int'(byte_cnt)) wdata_upd[b] = rx_data[3'(b % 8)];
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    err_inc    = 1'b0;
    tx_start   = 1'b0;
    wr_pm      = 1'b0;
    wr_dm      = 1'b0;
    rd_dm      = 1'b0;
    cpu_reset  = 1'b1;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (rx_done) begin
          case (rx_data)
            OP_RUN:                       next_state = RUN;
            OP_WR_PM, OP_WR_DM, OP_RD_DM: next_state = RX_ADDR;
            OP_DUMP, OP_PING:             next_state = TX_LOAD;
            default: begin
              next_state = TX_LOAD;
              err_inc    = 1'b1;
            end
          endcase
        end
      end
      RX_ADDR: begin
        if (rx_done) begin
          if (last_addr_byte) next_state = (opcode == OP_RD_DM) ? READ_WAIT : RX_DATA;
        end else if (tmo_hit) begin
          next_state = IDLE;
          err_inc    = 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_done) begin
          if (last_data_byte) next_state = WRITE;
        end else if (tmo_hit) begin
          next_state = IDLE;
          err_inc    = 1'b1;
        end
      end
      WRITE: begin
        wr_pm      = (opcode == OP_WR_PM);
        wr_dm      = (opcode == OP_WR_DM);
        next_state = TX_LOAD;
      end
      READ_WAIT: begin
        rd_dm = (wait_cnt == '0);
        if (rd_ready) next_state = TX_LOAD;
      end
      RUN: begin
        cpu_reset = run_done;
        if (run_done) next_state = TX_LOAD;
      end
      TX_LOAD: begin
        tx_start   = 1'b1;
        next_state = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) next_state = (tx_left == TXC_W'(1)) ? IDLE : TX_LOAD;
      end
      default: next_state = IDLE;
    endcase
    // Bytes arriving while a command is executing or replying are dropped.
    if (rx_done && (state inside {WRITE, READ_WAIT, RUN, TX_LOAD, TX_WAIT}))
      err_inc = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      opcode    <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      run_cnt   <= '0;
      wait_cnt  <= '0;
      tx_buf    <= '0;
      tx_left   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_count <= '0;
    end else begin
      state <= next_state;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        IDLE: begin
          if (rx_done) begin
            opcode   <= rx_data;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            run_cnt  <= '0;
            wait_cnt <= '0;
            if (rx_data == OP_DUMP) begin
              tx_buf  <= {pc, acc};
              tx_left <= TXC_W'(2 * DATA_BYTES);
            end else begin
              tx_buf  <= TXW'((rx_data == OP_PING) ? BYTE_PONG : BYTE_NAK);
              tx_left <= TXC_W'(1);
            end
          end
        end
        RX_ADDR: begin
          if (rx_done) begin
            mem_addr <= addr_upd;
            tmo_cnt  <= '0;
            byte_cnt <= last_addr_byte ? '0 : byte_cnt + 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_done) begin
            mem_wdata <= wdata_upd;
            tmo_cnt   <= '0;
            byte_cnt  <= last_data_byte ? '0 : byte_cnt + 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WRITE: begin
          tx_buf  <= TXW'(BYTE_ACK);
          tx_left <= TXC_W'(1);
        end
        READ_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (rd_ready) begin
            tx_buf  <= TXW'(mem_rdata);
            tx_left <= TXC_W'(DATA_BYTES);
          end
        end
        RUN: begin
          if (run_done) begin
            tx_buf  <= {pc, acc};
            tx_left <= TXC_W'(2 * DATA_BYTES);
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        TX_WAIT: begin
          if (tx_done) begin
            tx_buf  <= tx_buf >> 8;
            tx_left <= tx_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Directed bench for uart_debug_ctrl: host byte driver, transmitter and
// memory models, strobe monitors and hand-computed expected replies.
module tb_uart_debug_ctrl;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        wr_pm, wr_dm, rd_dm;
  logic [15:0] acc = '0;
  logic [15:0] pc = '0;
  logic        cpu_reset, busy;
  logic [7:0]  err_count;

  uart_debug_ctrl #(
    .DATA_BYTES(2), .ADDR_WIDTH(11), .RUN_CYCLES(256), .RD_LATENCY(1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_pm(wr_pm), .wr_dm(wr_dm), .rd_dm(rd_dm),
    .acc(acc), .pc(pc),
    .cpu_reset(cpu_reset), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data memory with one cycle of read latency.
  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (wr_dm) mem[mem_addr] <= mem_wdata;
    if (rd_dm) mem_rdata <= mem[mem_addr];
  end

  // Transmitter: captures each started byte and answers tx_done a few cycles later.
  logic [7:0] tx_q[$];
  bit  tx_busy = 0;
  int  tx_cnt = 0;
  int  dbl_start = 0;
  int  wr_dm_cnt = 0, wr_pm_cnt = 0, rd_dm_cnt = 0, low_cnt = 0;
  logic [10:0] last_addr = '0;
  logic [15:0] last_wdata = '0;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (reset) begin
      tx_busy = 0;
      tx_cnt  = 0;
    end else begin
      if (tx_busy) begin
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          tx_busy = 0;
        end else tx_cnt--;
      end
      if (tx_start) begin
        if (tx_busy) dbl_start++;
        tx_q.push_back(tx_data);
        tx_busy = 1;
        tx_cnt  = 4;
      end
    end
    if (wr_dm) begin
      wr_dm_cnt++;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
    if (wr_pm) wr_pm_cnt++;
    if (rd_dm) rd_dm_cnt++;
    if (!cpu_reset) low_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int n, input string tag);
    int cyc = 0;
    while ((busy || tx_q.size() < n) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_in_budget"}, 32'(cyc < 2000), 32'd1);
  endtask

  task automatic check_q(input string tag, input logic [7:0] exp[$]);
    check({tag, "_len"}, 32'(tx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(tx_q[i]), 32'(exp[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_strobes", {28'd0, tx_start, wr_pm, wr_dm, rd_dm}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write data memory 0x234 <= 0xABCD.
    send_byte(8'h03); send_byte(8'h34); send_byte(8'h02);
    send_byte(8'hCD); send_byte(8'hAB);
    wait_done(1, "wrdm");
    check("wrdm_count", 32'(wr_dm_cnt), 32'd1);
    check("wrdm_addr", 32'(last_addr), 32'h234);
    check("wrdm_wdata", 32'(last_wdata), 32'hABCD);
    check("wrdm_no_wrpm", 32'(wr_pm_cnt), 32'd0);
    check_q("wrdm_ack", '{8'h06});
    tx_q.delete();

    // Read it back, low byte first.
    send_byte(8'h04); send_byte(8'h34); send_byte(8'h02);
    wait_done(2, "rddm");
    check("rddm_count", 32'(rd_dm_cnt), 32'd1);
    check_q("rddm_data", '{8'hCD, 8'hAB});
    tx_q.delete();

    // RUN window then automatic dump of acc/pc.
    acc = 16'h0012;
    pc  = 16'h0040;
    low_cnt = 0;
    send_byte(8'h01);
    wait_done(4, "run");
    check("run_low_cycles", 32'(low_cnt), 32'd256);
    check_q("run_dump", '{8'h12, 8'h00, 8'h40, 8'h00});
    tx_q.delete();

    // Unknown opcode gets a NAK.
    send_byte(8'h7F);
    wait_done(1, "nak");
    check_q("nak_byte", '{8'hEE});
    check("nak_err", 32'(err_count), 32'd1);
    tx_q.delete();

    // Truncated WR_PM frame times out with no write.
    send_byte(8'h02);
    @(negedge clk);
    rx_data = 8'h10;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (TMO - 5) @(negedge clk);
    check("tmo_still_busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_no_wrpm", 32'(wr_pm_cnt), 32'd0);
    check("tmo_err", 32'(err_count), 32'd2);
    check("tmo_no_tx", 32'(tx_q.size()), 32'd0);

    // A byte arriving during the reply is discarded and counted.
    send_byte(8'h06);
    send_byte(8'h55);
    wait_done(1, "drop");
    check_q("drop_pong", '{8'hA5});
    check("drop_err", 32'(err_count), 32'd3);
    tx_q.delete();

    // Reset 100 cycles into RUN aborts it silently.
    send_byte(8'h01);
    repeat (100) @(negedge clk);
    check("midrun_cpu_low", 32'(cpu_reset), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_err_clr", 32'(err_count), 32'd0);
    repeat (300) @(negedge clk);
    check("midrun_no_tx", 32'(tx_q.size()), 32'd0);
    send_byte(8'h06);
    wait_done(1, "ping");
    check_q("ping_byte", '{8'hA5});

    check("no_double_start", 32'(dbl_start), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
